// File: rtl/saturate_pkg.sv
// Shared mode encodings and clamp-range helpers for the saturate_pipe block.
package saturate_pkg;

   localparam logic [1:0] MODE_WRAP = 2'b00;
   localparam logic [1:0] MODE_16   = 2'b01;
   localparam logic [1:0] MODE_24   = 2'b10;
   localparam logic [1:0] MODE_FULL = 2'b11;

   // Narrower output builds fold the 16/24 modes onto the full output range.
   function automatic int clamp_width(input logic [1:0] mode, input int ow);
      case (mode)
         MODE_16: return (ow < 24) ? ow : 16;
         MODE_24: return (ow < 24) ? ow : 24;
         default: return ow;
      endcase
   endfunction

   function automatic logic signed [63:0] lim_hi(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] lim_lo(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/sat_lane.sv
// One channel's clamp/wrap datapath and overflow detect; purely combinational.
module sat_lane
   import saturate_pkg::*;
#(
   parameter int DW = 32,
   parameter int OW = 24
) (
   input  logic [DW-1:0] din,
   input  logic [1:0]    mode,
   output logic [OW-1:0] dout,
   output logic          ovf
);

   // Working in 64 bits keeps compares uniform; DW is limited to 64.
   logic signed [63:0] x, hi, lo, r;
   logic               sat_unused;

   always_comb begin
      x   = 64'($signed(din));
      hi  = lim_hi(clamp_width(mode, OW));
      lo  = lim_lo(clamp_width(mode, OW));
      r   = x;
      ovf = 1'b0;
      if (mode != MODE_WRAP) begin
         if (x > hi) begin
            r   = hi;
            ovf = 1'b1;
         end else if (x < lo) begin
            r   = lo;
            ovf = 1'b1;
         end
      end
      dout = r[OW-1:0];
   end

   assign sat_unused = &{1'b0, r[63:OW]};

endmodule

// File: rtl/saturate_pipe.sv
// Two-stage multi-channel saturating pipeline with sticky overflow flags.
// Define SATURATE_OVFCNT_EN to build the per-channel overflow event counters.
module saturate_pipe
   import saturate_pkg::*;
#(
   parameter int DW   = 32,
   parameter int OW   = 24,
   parameter int CH   = 2,
   parameter int CNTW = 8
) (
   input  logic              sys_clk,
   input  logic              resetl,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CH*DW-1:0]  in_data,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH*OW-1:0]  out_data,
   input  logic              clr,
   output logic [CH-1:0]     ovf_flag,
   output logic [CH*CNTW-1:0] ovf_cnt
);

   logic [2:1]              vld_pipe;
   logic                    adv, acc;
   logic [CH-1:0][OW-1:0]   lane_out, s1_data, s2_data;
   logic [CH-1:0]           lane_ovf, ovf_evt;

   assign adv      = !vld_pipe[2] || out_ready;
   assign in_ready = !vld_pipe[1] || adv;
   assign acc      = in_valid && in_ready;

   for (genvar g = 0; g < CH; g++) begin : g_lane
      sat_lane #(.DW(DW), .OW(OW)) u_lane (
         .din  (in_data[g*DW +: DW]),
         .mode (in_mode),
         .dout (lane_out[g]),
         .ovf  (lane_ovf[g])
      );
   end

   // S1 may refill while S2 is stalled, so valids do not shift in lockstep.
   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         vld_pipe <= '0;
         s1_data  <= '0;
         s2_data  <= '0;
      end else begin
         if (acc) begin
            vld_pipe[1] <= 1'b1;
            s1_data     <= lane_out;
         end else if (adv) begin
            vld_pipe[1] <= 1'b0;
         end
         if (adv) begin
            vld_pipe[2] <= vld_pipe[1];
            s2_data     <= s1_data;
         end
      end
   end

   assign out_valid = vld_pipe[2];
   assign out_data  = s2_data;
   assign ovf_evt   = {CH{acc}} & lane_ovf;

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl)  ovf_flag <= '0;
      else if (clr) ovf_flag <= ovf_evt;
      else          ovf_flag <= ovf_flag | ovf_evt;
   end

`ifdef SATURATE_OVFCNT_EN
   logic [CH-1:0][CNTW-1:0] cnt_q;

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         cnt_q <= '0;
      end else begin
         for (int k = 0; k < CH; k++) begin
            if (clr)
               cnt_q[k] <= {{(CNTW-1){1'b0}}, ovf_evt[k]};
            else if (ovf_evt[k] && cnt_q[k] != {CNTW{1'b1}})
               cnt_q[k] <= cnt_q[k] + CNTW'(1);
         end
      end
   end

   assign ovf_cnt = cnt_q;
`else
   assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_saturate_pipe.sv
// Directed self-checking bench for saturate_pipe (default parameters).
module tb_saturate_pipe;

   localparam int DW = 32, OW = 24, CH = 2, CNTW = 8;
`ifdef SATURATE_OVFCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic               sys_clk, resetl, in_valid, in_ready, out_valid, out_ready, clr;
   logic [CH*DW-1:0]   in_data;
   logic [1:0]         in_mode;
   logic [CH*OW-1:0]   out_data;
   logic [CH-1:0]      ovf_flag;
   logic [CH*CNTW-1:0] ovf_cnt;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   saturate_pipe #(.DW(DW), .OW(OW), .CH(CH), .CNTW(CNTW)) dut (
      .sys_clk  (sys_clk),
      .resetl   (resetl),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_mode  (in_mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .clr      (clr),
      .ovf_flag (ovf_flag),
      .ovf_cnt  (ovf_cnt)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] m, input logic [31:0] c1, input logic [31:0] c0);
      in_mode  = m;
      in_data  = {c1, c0};
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   function automatic logic [47:0] bp_exp(input int i);
      return {24'(16'h100 + i), 24'(i + 1)};
   endfunction

   initial begin
      int sent, got;
      bit stall, seen, prev_hold, fire;
      logic [47:0] prev_data;

      resetl = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'b00;
      out_ready = 1'b1; clr = 1'b0;
      step(); step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready, 1);
      chk("rst_out_data",  out_data, 0);
      chk("rst_flag",      ovf_flag, 0);
      chk("rst_cnt",       ovf_cnt, 0);
      resetl = 1'b1;
      step();

      // mode 01 overflow on ch0
      beat(2'b01, 32'h0000_0010, 32'h0001_2345);
      chk("m16_flag_t1",  ovf_flag, 2'b01);
      chk("m16_cnt_t1",   ovf_cnt, CNT_EN ? 16'h0001 : 16'h0000);
      chk("m16_vld_t1",   out_valid, 0);
      step();
      chk("m16_vld_t2",   out_valid, 1);
      chk("m16_data",     out_data, 48'h000010_007FFF);

      // mode 10: ch1 negative clamp, ch0 in range
      beat(2'b10, 32'hFF00_0000, 32'h0000_1234);
      chk("m24_flag",     ovf_flag, 2'b11);
      chk("m24_cnt",      ovf_cnt, CNT_EN ? 16'h0101 : 16'h0000);
      step();
      chk("m24_data",     out_data, 48'h800000_001234);

      clr = 1'b1; step(); clr = 1'b0;
      chk("clr_flag",     ovf_flag, 0);
      chk("clr_cnt",      ovf_cnt, 0);

      // wrap mode never flags
      beat(2'b00, 32'h8000_0000, 32'h1234_5678);
      chk("wrap_flag",    ovf_flag, 0);
      chk("wrap_cnt",     ovf_cnt, 0);
      step();
      chk("wrap_data",    out_data, 48'h000000_345678);

      // mode 11 boundaries: max in range, min-1 clamps
      beat(2'b11, 32'hFF7F_FFFF, 32'h007F_FFFF);
      chk("full_flag",    ovf_flag, 2'b10);
      chk("full_cnt",     ovf_cnt, CNT_EN ? 16'h0100 : 16'h0000);
      step();
      chk("full_data",    out_data, 48'h800000_7FFFFF);

      // mode 01 exact limits do not flag
      beat(2'b01, 32'hFFFF_8000, 32'h0000_7FFF);
      chk("m16_lim_flag", ovf_flag, 2'b10);
      step();
      chk("m16_lim_data", out_data, 48'hFF8000_007FFF);

      // backpressure: 4 beats, out_ready low for 3 cycles after the first
      clr = 1'b1; step(); clr = 1'b0;
      sent = 0; got = 0; stall = 0; prev_hold = 0; prev_data = '0;
      in_mode = 2'b00; in_data = {32'h100, 32'h1}; in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         out_ready = !(c >= 1 && c <= 3);
         #1;
         if (in_valid && !in_ready) stall = 1;
         if (prev_hold) begin
            chk("hold_vld",  out_valid, 1);
            chk("hold_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            chk($sformatf("bp_beat%0d", got), out_data, bp_exp(got));
            got++;
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         fire = in_valid && in_ready;
         step();
         if (fire) begin
            sent++;
            if (sent < 4) in_data = {32'(32'h100 + sent), 32'(sent + 1)};
            else          in_valid = 1'b0;
         end
      end
      out_ready = 1'b1;
      chk("bp_stall", stall, 1);
      chk("bp_sent",  sent, 4);
      chk("bp_got",   got, 4);
      chk("bp_flag",  ovf_flag, 0);

      // counter saturation, then clr coincident with an event
      clr = 1'b1; step(); clr = 1'b0;
      in_mode = 2'b01; in_data = {32'h0, 32'h0001_0000}; in_valid = 1'b1;
      repeat (300) step();
      in_valid = 1'b0;
      chk("sat_cnt",  ovf_cnt, CNT_EN ? 16'h00FF : 16'h0000);
      chk("sat_flag", ovf_flag, 2'b01);
      clr = 1'b1; in_valid = 1'b1;
      step();
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_evt_cnt",  ovf_cnt, CNT_EN ? 16'h0001 : 16'h0000);
      chk("clr_evt_flag", ovf_flag, 2'b01);

      // reset with two beats in flight
      repeat (3) step();
      out_ready = 1'b0;
      in_data = {32'h0, 32'h0002_0000}; in_valid = 1'b1;
      step(); step();
      in_valid = 1'b0;
      chk("fl_vld", out_valid, 1);
      resetl = 1'b0;
      #1;
      chk("mr_out_valid", out_valid, 0);
      chk("mr_flag",      ovf_flag, 0);
      chk("mr_cnt",       ovf_cnt, 0);
      chk("mr_in_ready",  in_ready, 1);
      step(); step();
      resetl = 1'b1; out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         step();
         if (out_valid) seen = 1;
      end
      chk("mr_no_stale", seen, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/saturate_pipe.md
SATURATE_PIPE -- requirements
Module: saturate_pipe

Interface
REQ-001 Parameter DW, default 32, input sample width per channel (signed two's complement).
REQ-002 Parameter OW, default 24, output sample width per channel; legal range 16..DW.
REQ-003 Parameter CH, default 2, number of independent channels.
REQ-004 Parameter CNTW, default 8, width of each per-channel overflow counter.
REQ-005 sys_clk  in  1  single clock; all state on rising edge.
REQ-006 resetl  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  input beat present.
REQ-008 in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
REQ-009 in_data  in  CH*DW  channel k in bits [k*DW +: DW].
REQ-010 in_mode  in  2  00 wrap, 01 sixteen, 10 twentyfour, 11 full (OW); sampled with the beat.
REQ-011 out_valid  out  1  output beat present.
REQ-012 out_ready  in  1  output beat consumed when out_valid and out_ready are both high.
REQ-013 out_data  out  CH*OW  channel k in bits [k*OW +: OW], sign-extended to OW.
REQ-014 clr  in  1  synchronous clear of overflow flags and counters.
REQ-015 ovf_flag  out  CH  sticky per-channel overflow flag.
REQ-016 ovf_cnt  out  CH*CNTW  per-channel overflow event counters.

Function
REQ-017 Modes: 01 clamps to [-2^15, 2^15-1]; 10 clamps to [-2^23, 2^23-1]; 11 clamps to [-2^(OW-1), 2^(OW-1)-1]; 00 passes the low OW bits unclamped (wrap).
REQ-018 Modes 01 and 10 on a build with OW<24 behave as mode 11.
REQ-019 The pipeline has two register stages (S1 compute, S2 output); latency is 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-020 S2 loads when S2 is empty or out_ready is high; S1 advances under the same condition.
REQ-021 in_ready = !S1_valid || S1_advance (combinational); sustained throughput is one beat per cycle.
REQ-022 While out_valid is high and out_ready is low, out_data and out_valid hold stable.
REQ-023 A channel overflow event is a clamp (value outside range) in modes 01/10/11 on an accepted beat; wrap mode never raises an event.
REQ-024 An overflow event sets ovf_flag[k] and increments ovf_cnt[k] one cycle after acceptance; the counter saturates at 2^CNTW-1.
REQ-025 clr zeroes flags and counters; clr together with an event in the same cycle leaves flag=1 and counter=1.
REQ-026 clr does not affect pipeline data or handshakes.

Reset
REQ-027 While resetl is low: S1/S2 valid=0, out_valid=0, out_data=0, ovf_flag=0, ovf_cnt=0; in_ready=1.
REQ-028 Reset asserted mid-transfer discards all in-flight beats; no beat is output after release without a new acceptance.

Configuration
REQ-029 Macro SATURATE_OVFCNT_EN: when defined, counters are per REQ-024/025; when undefined, ovf_cnt is tied to 0, no counter flops exist, and ovf_flag behaviour is unchanged.

Structure
REQ-030 Package saturate_pkg holds the mode encoding constants (MODE_WRAP, MODE_16, MODE_24, MODE_FULL) and range-limit constant functions.
REQ-031 Sub-module sat_lane (combinational: one channel's clamp plus overflow bit) is instantiated CH times; the pipeline registers reside in saturate_pipe.

Verification
REQ-032 Mode 01, ch0 in=0x0001_2345 -> out=0x007FFF, ovf_flag[0]=1, ovf_cnt[0]=1 after 2 cycles.
REQ-033 Mode 10, ch1 in=0xFF00_0000 -> out=0x800000, ovf_flag[1]=1; ch0 in=0x0000_1234 -> 0x001234 with no flag.
REQ-034 Mode 00, in=0x1234_5678 -> out=0x345678, no flag, no count.
REQ-035 Back-to-back 4 beats with out_ready low for 3 cycles after the first -> in_ready drops after S1/S2 fill; all 4 beats emerge in order with none lost or duplicated.
REQ-036 300 consecutive overflowing beats with CNTW=8 -> ovf_cnt=255; clr coincident with an overflow event -> counter=1, flag=1.
REQ-037 resetl pulsed low with 2 beats in flight -> out_valid=0 and flags/counters=0 immediately; no stale beat appears after release.
